// File: rtl/iter_divider.sv
// Radix-2 restoring integer divider (DIV/DIVU/REM/REMU and W forms), one op in flight.
// Latency accept->out_valid: N+3 cycles (N = XLEN or WLEN), 3 for special cases when fast path enabled.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts everything.
//
// Ports: clk, reset (sync, active-high), flush; request side in_valid/in_ready with
//   a, b, op (0=quotient, 1=remainder), is_signed, word; response side
//   out_valid/out_ready with result; busy = not idle.
// Optional macro DIVIDER_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip
//   the iteration phase (PREP -> FIX). Results are identical either way.
module iter_divider #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            op,
    input  logic            is_signed,
    input  logic            word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam logic MODOP = 1'b1;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [XLEN-1:0]   r_a, r_b, r_a_ext, r_q, r_rem, r_div, r_result;
    logic              r_op, r_signed, r_word, r_sa, r_sb, r_bz, r_ovf;
    logic [CW-1:0]     r_cnt;

    // Operand extension: word mode truncates to WLEN then sign/zero-extends,
    // so the top bit of the extended value is always the N-bit sign.
    logic [WLEN-1:0]   w_a_lo, w_b_lo;
    logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_q_init;
    logic              w_sa, w_sb, w_bz, w_ovf;

    assign w_a_lo  = r_a[WLEN-1:0];
    assign w_b_lo  = r_b[WLEN-1:0];
    assign w_a_ext = !r_word ? r_a :
                     r_signed ? {{(XLEN-WLEN){w_a_lo[WLEN-1]}}, w_a_lo}
                              : {{(XLEN-WLEN){1'b0}}, w_a_lo};
    assign w_b_ext = !r_word ? r_b :
                     r_signed ? {{(XLEN-WLEN){w_b_lo[WLEN-1]}}, w_b_lo}
                              : {{(XLEN-WLEN){1'b0}}, w_b_lo};
    assign w_sa    = r_signed & w_a_ext[XLEN-1];
    assign w_sb    = r_signed & w_b_ext[XLEN-1];
    // Negating the most-negative value yields itself, which read as unsigned is the magnitude.
    assign w_a_mag = w_sa ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_sb ? -w_b_ext : w_b_ext;
    // Left-align the dividend so the bit shifted into the remainder is always r_q[XLEN-1];
    // after WLEN steps the quotient sits in the low WLEN bits with zeros above.
    assign w_q_init = r_word ? (w_a_mag << (XLEN-WLEN)) : w_a_mag;
    assign w_bz    = (w_b_ext == '0);
    assign w_ovf   = r_signed && (w_a_ext == (r_word ? MIN_W : MIN_X)) && (w_b_ext == '1);

    // One restoring step. The shifted remainder needs one extra bit for the compare.
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_rem_sub;
    logic              w_ge;

    assign w_rem_sh  = {r_rem, r_q[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_div;

    // Sign fix-up and special-case override.
    logic [XLEN-1:0]   w_quo, w_rmd, w_sel, w_res;

    assign w_quo = (r_sa ^ r_sb) ? -r_q : r_q;
    assign w_rmd = r_sa ? -r_rem : r_rem;
    always_comb begin
        w_sel = '0;
        if (r_op == MODOP)
            w_sel = r_bz ? r_a_ext : (r_ovf ? '0 : w_rmd);
        else
            w_sel = r_bz ? '1 : (r_ovf ? r_a_ext : w_quo);
    end
    assign w_res = r_word ? {{(XLEN-WLEN){w_sel[WLEN-1]}}, w_sel[WLEN-1:0]} : w_sel;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_PREP;
            S_PREP: begin
`ifdef DIVIDER_FAST_SPECIAL_EN
                w_state_nxt = (w_bz || w_ovf) ? S_FIX : S_CALC;
`else
                w_state_nxt = S_CALC;
`endif
            end
            S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a <= '0; r_b <= '0; r_a_ext <= '0; r_q <= '0; r_rem <= '0;
            r_div <= '0; r_result <= '0; r_op <= 1'b0; r_signed <= 1'b0;
            r_word <= 1'b0; r_sa <= 1'b0; r_sb <= 1'b0; r_bz <= 1'b0;
            r_ovf <= 1'b0; r_cnt <= '0;
        end else if (flush) begin
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_op     <= op;
                    r_signed <= is_signed;
                    r_word   <= word;
                end
                S_PREP: begin
                    r_a_ext <= w_a_ext;
                    r_sa    <= w_sa;
                    r_sb    <= w_sb;
                    r_bz    <= w_bz;
                    r_ovf   <= w_ovf;
                    r_q     <= w_q_init;
                    r_div   <= w_b_mag;
                    r_rem   <= '0;
                    r_cnt   <= r_word ? CW'(WLEN-1) : CW'(XLEN-1);
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX:   r_result <= w_res;
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latency, handshake hold, flush abort.
// Latency measured in cycles from the accepting cycle to the first cycle out_valid is seen.
// Outputs sampled 1 time unit after the rising edge; inputs driven then or on the falling edge.
module tb_iter_divider;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, op, is_signed, word;
    logic        out_valid, out_ready, busy;
    logic [63:0] a, b, result;
    int          checks = 0;
    int          errors = 0;

    localparam int LAT_X = 67;
    localparam int LAT_W = 35;
`ifdef DIVIDER_FAST_SPECIAL_EN
    localparam int LAT_SX = 3;
    localparam int LAT_SW = 3;
`else
    localparam int LAT_SX = 67;
    localparam int LAT_SW = 35;
`endif

    iter_divider #(.XLEN(64), .WLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .op(op), .is_signed(is_signed),
        .word(word), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure latency, optionally hold out_ready low, then consume.
    task automatic run(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic top, input logic tsg, input logic twd,
                       input logic [63:0] exp, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; op = top; is_signed = tsg; word = twd;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h1234_5678_9ABC_DEF0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_res"}, result, exp);
            check({tag, ".hold_vld"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 1'b0; is_signed = 1'b0; word = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.result", result, 64'd0);
        reset = 1'b0;

        // Unsigned basics
        run("divu", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, LAT_X, 0);
        run("modu", 64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 64'd2, LAT_X, 0);
        // Signed: truncate toward zero, remainder follows dividend
        run("div_n7_2", -64'sd7, 64'd2, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, LAT_X, 0);
        run("mod_n7_2", -64'sd7, 64'd2, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_X, 0);
        run("mod_7_n2", 64'd7, -64'sd2, 1'b1, 1'b1, 1'b0, 64'd1, LAT_X, 0);
        run("div_7_n2", 64'd7, -64'sd2, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, LAT_X, 0);
        // Signed overflow, word and full width
        run("divw_ovf", 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1,
            64'hFFFF_FFFF_8000_0000, LAT_SW, 0);
        run("modw_ovf", 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1,
            64'd0, LAT_SW, 0);
        run("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0,
            64'h8000_0000_0000_0000, LAT_SX, 0);
        run("mod_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
            64'd0, LAT_SX, 0);
        // Divide by zero
        run("divu_b0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SX, 0);
        run("mod_b0", -64'sd5, 64'd0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, LAT_SX, 0);
        run("div_b0", -64'sd5, 64'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SX, 0);
        run("divuw_b0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, LAT_SW, 0);
        // Word mode, non-special: truncation and result sign-extension
        run("divuw", 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 1'b0, 1'b0, 1'b1,
            64'h0000_0000_7FFF_FFFF, LAT_W, 0);
        run("remw", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, LAT_W, 0);
        // Result held while consumer stalls
        run("hold", 64'd1000, 64'd33, 1'b0, 1'b0, 1'b0, 64'd30, LAT_X, 10);

        // Flush mid-CALC with a competing request
        @(negedge clk);
        a = 64'd100; b = 64'd7; op = 1'b0; is_signed = 1'b0; word = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("flush.busy_before", 64'(busy), 64'd1);
        flush = 1'b1; in_valid = 1'b1; a = 64'd50; b = 64'd5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush.in_ready", 64'(in_ready), 64'd1);
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush.not_taken", 64'(busy), 64'd0);
        check("flush.no_valid", 64'(out_valid), 64'd0);
        run("post_flush", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, LAT_X, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
